// File: rtl/icache_data_ram_cfg.sv
// Parametrised single-port I-cache data array with byte enables, read-during-write mode select,
// optional output register, and a hardware clear sweep after reset or flush.
module icache_data_ram_cfg #(
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned WR_MODE = 0,
  parameter int unsigned OUT_REG = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_i,
  output logic                  ready_o,
  input  logic                  en_i,
  input  logic                  wr_i,
  input  logic [ADDR_W-1:0]     addr_i,
  input  logic [DATA_W/8-1:0]   be_i,
  input  logic [DATA_W-1:0]     data_i,
  output logic [DATA_W-1:0]     data_o,
  output logic                  valid_o
);

  localparam int unsigned NBYTES = DATA_W / 8;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  typedef enum logic {
    ST_CLEAR,
    ST_READY
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;

  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;

  logic                accept;
  logic [DATA_W-1:0]   old_data;
  logic [DATA_W-1:0]   merged_data;
  logic [DATA_W-1:0]   rd_result;

  logic                s1_vld_q, s1_vld_d;
  logic [DATA_W-1:0]   s1_data_q, s1_data_d;

  // Sweep / idle control
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    ready_o   = (state_q == ST_READY);
    case (state_q)
      ST_CLEAR: begin
        if (flush_i) begin
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + ADDR_W'(1);
          if (clr_cnt_q == '1) begin
            state_d = ST_READY;
          end
        end
      end
      ST_READY: begin
        if (flush_i) begin
          state_d   = ST_CLEAR;
          clr_cnt_d = '0;
        end
      end
      default: begin
        state_d   = ST_CLEAR;
        clr_cnt_d = '0;
      end
    endcase
  end

  // Access datapath: byte merge feeds both the array write and write-first read data
  always_comb begin
    accept   = en_i & ready_o;
    old_data = mem_q[addr_i];
    merged_data = old_data;
    for (int unsigned n = 0; n < NBYTES; n++) begin
      if (wr_i && be_i[n]) begin
        merged_data[8*n +: 8] = data_i[8*n +: 8];
      end
    end
    rd_result = (WR_MODE != 0) ? merged_data : old_data;

    mem_we    = 1'b0;
    mem_waddr = addr_i;
    mem_wdata = merged_data;
    if (state_q == ST_CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = clr_cnt_q;
      mem_wdata = '0;
    end else if (accept && wr_i && (|be_i)) begin
      mem_we = 1'b1;
    end

    s1_vld_d  = accept;
    s1_data_d = accept ? rd_result : s1_data_q;
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
      s1_vld_q  <= 1'b0;
      s1_data_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      s1_vld_q  <= s1_vld_d;
      s1_data_q <= s1_data_d;
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic              s2_vld_q, s2_vld_d;
    logic [DATA_W-1:0] s2_data_q, s2_data_d;

    always_comb begin
      s2_vld_d  = s1_vld_q;
      s2_data_d = s1_vld_q ? s1_data_q : s2_data_q;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s2_vld_q  <= 1'b0;
        s2_data_q <= '0;
      end else begin
        s2_vld_q  <= s2_vld_d;
        s2_data_q <= s2_data_d;
      end
    end

    assign valid_o = s2_vld_q;
    assign data_o  = s2_data_q;
  end else begin : g_no_out_reg
    assign valid_o = s1_vld_q;
    assign data_o  = s1_data_q;
  end

endmodule

// File: tb/tb_icache_data_ram_cfg.sv
// Directed bench driving three array variants in lockstep: read-first, write-first, and
// read-first with the extra output register.
module tb_icache_data_ram_cfg;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        en;
  logic        wr;
  logic [9:0]  addr;
  logic [7:0]  be;
  logic [63:0] wdata;

  logic        rdy  [3];
  logic        vld  [3];
  logic [63:0] dout [3];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  icache_data_ram_cfg #(.DATA_W(64), .ADDR_W(10), .WR_MODE(0), .OUT_REG(0)) u_rf (
    .clk(clk), .rst(rst), .flush_i(flush), .ready_o(rdy[0]), .en_i(en), .wr_i(wr),
    .addr_i(addr), .be_i(be), .data_i(wdata), .data_o(dout[0]), .valid_o(vld[0]));

  icache_data_ram_cfg #(.DATA_W(64), .ADDR_W(10), .WR_MODE(1), .OUT_REG(0)) u_wf (
    .clk(clk), .rst(rst), .flush_i(flush), .ready_o(rdy[1]), .en_i(en), .wr_i(wr),
    .addr_i(addr), .be_i(be), .data_i(wdata), .data_o(dout[1]), .valid_o(vld[1]));

  icache_data_ram_cfg #(.DATA_W(64), .ADDR_W(10), .WR_MODE(0), .OUT_REG(1)) u_or (
    .clk(clk), .rst(rst), .flush_i(flush), .ready_o(rdy[2]), .en_i(en), .wr_i(wr),
    .addr_i(addr), .be_i(be), .data_i(wdata), .data_o(dout[2]), .valid_o(vld[2]));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!rdy[0] && n < 3000) begin
      tick();
      n++;
    end
  endtask

  // One accepted access; e0 = read-first result, e1 = write-first result
  task automatic access(input string tag, input logic w, input logic [9:0] a,
                        input logic [7:0] b, input logic [63:0] d,
                        input logic [63:0] e0, input logic [63:0] e1);
    en = 1'b1; wr = w; addr = a; be = b; wdata = d;
    tick();
    en = 1'b0; wr = 1'b0;
    check({tag, "_rf_vld"}, 64'(vld[0]), 64'd1);
    check({tag, "_rf_dat"}, dout[0], e0);
    check({tag, "_wf_vld"}, 64'(vld[1]), 64'd1);
    check({tag, "_wf_dat"}, dout[1], e1);
    check({tag, "_or_early"}, 64'(vld[2]), 64'd0);
    tick();
    check({tag, "_or_vld"}, 64'(vld[2]), 64'd1);
    check({tag, "_or_dat"}, dout[2], e0);
    check({tag, "_rf_drop"}, 64'(vld[0]), 64'd0);
    check({tag, "_rf_hold"}, dout[0], e0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    logic [63:0] vals [4];

    rst = 1'b1; flush = 1'b0; en = 1'b0; wr = 1'b0;
    addr = '0; be = '0; wdata = '0;
    tick(); tick();
    for (int i = 0; i < 3; i++) begin
      check("rst_ready", 64'(rdy[i]), 64'd0);
      check("rst_valid", 64'(vld[i]), 64'd0);
      check("rst_data",  dout[i], 64'd0);
    end

    rst = 1'b0;
    check("sweep_start_ready", 64'(rdy[0]), 64'd0);
    wait_ready(n);
    check("sweep_len", 64'(n), 64'd1024);
    check("sweep_ready_or", 64'(rdy[2]), 64'd1);

    access("rd3ff", 1'b0, 10'h3FF, 8'h00, 64'h0, 64'h0, 64'h0);

    access("wr5", 1'b1, 10'h005, 8'hFF, 64'h1122334455667788,
           64'h0, 64'h1122334455667788);
    access("rd5", 1'b0, 10'h005, 8'h00, 64'h0,
           64'h1122334455667788, 64'h1122334455667788);
    access("wr5_be0f", 1'b1, 10'h005, 8'h0F, 64'hAAAAAAAAAAAAAAAA,
           64'h1122334455667788, 64'h11223344AAAAAAAA);
    access("rd5_merged", 1'b0, 10'h005, 8'h00, 64'h0,
           64'h11223344AAAAAAAA, 64'h11223344AAAAAAAA);
    access("wr5_be00", 1'b1, 10'h005, 8'h00, 64'hDEADBEEFDEADBEEF,
           64'h11223344AAAAAAAA, 64'h11223344AAAAAAAA);

    access("wr10", 1'b1, 10'h010, 8'hFF, 64'h0123456789ABCDEF,
           64'h0, 64'h0123456789ABCDEF);
    access("rdw_mode", 1'b1, 10'h010, 8'hFF, 64'hFFFFFFFFFFFFFFFF,
           64'h0123456789ABCDEF, 64'hFFFFFFFFFFFFFFFF);

    vals[0] = 64'h0000000000000A01;
    vals[1] = 64'h00000000000B0002;
    vals[2] = 64'h000000000C000003;
    vals[3] = 64'hD000000000000004;
    for (int i = 0; i < 4; i++) begin
      access("wr_stream", 1'b1, 10'(32 + i), 8'hFF, vals[i], 64'h0, vals[i]);
    end

    // Back-to-back reads: read-first copy answers after 1 cycle, registered copy after 2
    for (int i = 0; i < 6; i++) begin
      en = (i < 4); wr = 1'b0; addr = 10'(32 + (i % 4));
      tick();
      check("stream_rf_vld", 64'(vld[0]), (i < 4) ? 64'd1 : 64'd0);
      if (i < 4) check("stream_rf_dat", dout[0], vals[i]);
      check("stream_or_vld", 64'(vld[2]), (i >= 1 && i < 5) ? 64'd1 : 64'd0);
      if (i >= 1 && i < 5) check("stream_or_dat", dout[2], vals[i-1]);
    end
    en = 1'b0;
    tick();

    // Flush coinciding with a write: the write still reports, then the sweep zeroes it
    flush = 1'b1; en = 1'b1; wr = 1'b1; addr = 10'h030; be = 8'hFF; wdata = 64'h5555AAAA5555AAAA;
    tick();
    flush = 1'b0; en = 1'b0; wr = 1'b0;
    check("flush_wr_rf_vld", 64'(vld[0]), 64'd1);
    check("flush_wr_rf_dat", dout[0], 64'h0);
    check("flush_wr_wf_dat", dout[1], 64'h5555AAAA5555AAAA);
    check("flush_ready_fall", 64'(rdy[0]), 64'd0);
    tick();
    check("flush_or_inflight", 64'(vld[2]), 64'd1);
    check("flush_or_dat", dout[2], 64'h0);
    for (int i = 2; i < 500; i++) begin
      en = (i < 10); addr = 10'h005;
      tick();
      if (i < 12) check("notready_drop", 64'(vld[0] | vld[2]), 64'd0);
    end
    en = 1'b0;
    check("clear_hold_wf", dout[1], 64'h5555AAAA5555AAAA);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    wait_ready(n);
    check("restart_len", 64'(n), 64'd1024);
    access("clr5",  1'b0, 10'h005, 8'h00, 64'h0, 64'h0, 64'h0);
    access("clr10", 1'b0, 10'h010, 8'h00, 64'h0, 64'h0, 64'h0);
    access("clr30", 1'b0, 10'h030, 8'h00, 64'h0, 64'h0, 64'h0);
    access("wr7", 1'b1, 10'h007, 8'hFF, 64'h7777, 64'h0, 64'h7777);

    flush = 1'b1;
    tick();
    flush = 1'b0;
    wait_ready(n);
    check("flush_ready_len", 64'(n), 64'd1024);
    access("clr7", 1'b0, 10'h007, 8'h00, 64'h0, 64'h0, 64'h0);

    // Reset with an access in flight kills the pending valid
    en = 1'b1; addr = 10'h007;
    tick();
    en = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_kill_rf", 64'(vld[0]), 64'd0);
    check("rst_kill_or", 64'(vld[2]), 64'd0);
    check("rst_kill_ready", 64'(rdy[0]), 64'd0);
    #1 rst = 1'b0;
    for (int i = 0; i < 300; i++) tick();
    check("cnt300_ready", 64'(rdy[0]), 64'd0);
    rst = 1'b1;
    #2 rst = 1'b0;
    wait_ready(n);
    check("rst300_len", 64'(n), 64'd1024);
    access("post_rst", 1'b0, 10'h3FF, 8'h00, 64'h0, 64'h0, 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
